// File: rtl/ps2_host_cmd_ctrl_pkg.sv
// Shared PS/2 byte constants and sequencer state encoding for the host command controller.
package ps2_host_cmd_ctrl_pkg;

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] RSP_ACK     = 8'hFA;
   localparam logic [7:0] RSP_RESEND  = 8'hFE;
   localparam logic [7:0] CMD_RESET   = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND_CMD  = 3'd1,
      ST_WAIT_ACK1 = 3'd2,
      ST_SEND_ARG  = 3'd3,
      ST_WAIT_ACK2 = 3'd4,
      ST_DONE      = 3'd5,
      ST_ERR       = 3'd6
   } state_t;

   // True for the two keyboard replies the sequencer swallows while waiting.
   function automatic logic is_reply(input logic [7:0] b);
      return (b == RSP_ACK) || (b == RSP_RESEND);
   endfunction

endpackage

// File: rtl/ps2_host_cmd_ctrl_ack_timer.sv
// Reply-wait cycle counter: held at zero while cleared, counts while enabled,
// flags expiry on the TIMEOUT_CYCLES-1 count.
module ps2_host_cmd_ctrl_ack_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + TW'(1);
   end

   assign expire_c = en && (cnt == TW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ps2_host_cmd_ctrl.sv
// PS/2 host command sequencer: LED updates and single command bytes with ACK/RESEND handling.
// Define PS2_CMD_STATS_EN to enable the saturating aborted-sequence counter on err_cnt.
module ps2_host_cmd_ctrl
   import ps2_host_cmd_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] led_state,
   input  logic       cmd_req,
   input  logic [7:0] cmd_byte,
   output logic       cmd_busy,
   output logic       cmd_done,
   output logic       cmd_err,
   output logic [7:0] err_cnt,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       dn_valid,
   output logic [7:0] dn_data,
   input  logic       dn_ready,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   input  logic       tx_ready
);

   localparam int unsigned RW = $clog2(MAX_RETRY + 1);

   state_t        state, state_nxt;
   logic [2:0]    led_shadow, shadow_nxt;
   logic [2:0]    led_lat, lat_nxt;
   logic          is_led, is_led_nxt;
   logic [RW-1:0] retry, retry_nxt;
   logic          tx_valid_nxt, busy_nxt, done_nxt, err_nxt;
   logic [7:0]    tx_data_nxt;
   logic          in_wait, consume, expire_c;

   assign in_wait = (state == ST_WAIT_ACK1) || (state == ST_WAIT_ACK2);
   assign consume = rx_valid && in_wait && is_reply(rx_data);

   // Replies are swallowed only while waiting; everything else passes straight through.
   assign rx_ready = consume ? 1'b1 : dn_ready;
   assign dn_valid = consume ? 1'b0 : rx_valid;
   assign dn_data  = rx_data;

   ps2_host_cmd_ctrl_ack_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_ack_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (!in_wait),
      .en      (in_wait),
      .expire_c(expire_c)
   );

   always_comb begin
      state_nxt    = state;
      shadow_nxt   = led_shadow;
      lat_nxt      = led_lat;
      is_led_nxt   = is_led;
      retry_nxt    = retry;
      tx_valid_nxt = tx_valid;
      tx_data_nxt  = tx_data;
      busy_nxt     = cmd_busy;
      done_nxt     = 1'b0;
      err_nxt      = 1'b0;
      case (state)
         ST_IDLE: begin
            busy_nxt     = 1'b0;
            tx_valid_nxt = 1'b0;
            // LED mismatch outranks an explicit command request.
            if (led_state != led_shadow) begin
               state_nxt    = ST_SEND_CMD;
               lat_nxt      = led_state;
               is_led_nxt   = 1'b1;
               retry_nxt    = '0;
               tx_valid_nxt = 1'b1;
               tx_data_nxt  = CMD_SET_LED;
               busy_nxt     = 1'b1;
            end else if (cmd_req) begin
               state_nxt    = ST_SEND_CMD;
               is_led_nxt   = 1'b0;
               retry_nxt    = '0;
               tx_valid_nxt = 1'b1;
               tx_data_nxt  = cmd_byte;
               busy_nxt     = 1'b1;
            end
         end
         ST_SEND_CMD, ST_SEND_ARG: begin
            if (tx_ready) begin
               tx_valid_nxt = 1'b0;
               state_nxt    = (state == ST_SEND_CMD) ? ST_WAIT_ACK1 : ST_WAIT_ACK2;
            end
         end
         ST_WAIT_ACK1, ST_WAIT_ACK2: begin
            if (consume && (rx_data == RSP_ACK)) begin
               if ((state == ST_WAIT_ACK1) && is_led) begin
                  state_nxt    = ST_SEND_ARG;
                  retry_nxt    = '0;
                  tx_valid_nxt = 1'b1;
                  tx_data_nxt  = {5'b0, led_lat};
               end else begin
                  state_nxt = ST_DONE;
                  done_nxt  = 1'b1;
               end
            end else if (consume || expire_c) begin
               // A received RESEND takes precedence over a coincident timeout; both retry.
               if (retry < RW'(MAX_RETRY)) begin
                  retry_nxt    = retry + RW'(1);
                  tx_valid_nxt = 1'b1;
                  state_nxt    = (state == ST_WAIT_ACK1) ? ST_SEND_CMD : ST_SEND_ARG;
               end else begin
                  state_nxt = ST_ERR;
                  err_nxt   = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (is_led) shadow_nxt = led_lat;
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
         end
         ST_ERR: begin
            shadow_nxt = led_lat;
            state_nxt  = ST_IDLE;
            busy_nxt   = 1'b0;
         end
         default: begin
            state_nxt    = ST_IDLE;
            tx_valid_nxt = 1'b0;
            busy_nxt     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         led_shadow <= '0;
         led_lat    <= '0;
         is_led     <= 1'b0;
         retry      <= '0;
         tx_valid   <= 1'b0;
         tx_data    <= '0;
         cmd_busy   <= 1'b0;
         cmd_done   <= 1'b0;
         cmd_err    <= 1'b0;
      end else begin
         state      <= state_nxt;
         led_shadow <= shadow_nxt;
         led_lat    <= lat_nxt;
         is_led     <= is_led_nxt;
         retry      <= retry_nxt;
         tx_valid   <= tx_valid_nxt;
         tx_data    <= tx_data_nxt;
         cmd_busy   <= busy_nxt;
         cmd_done   <= done_nxt;
         cmd_err    <= err_nxt;
      end
   end

`ifdef PS2_CMD_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_cnt <= '0;
      else if ((state_nxt == ST_ERR) && (state != ST_ERR) && (err_cnt != 8'hFF))
         err_cnt <= err_cnt + 8'd1;
   end
`else
   assign err_cnt = 8'h00;
`endif

endmodule
